q_update_ctrl: RTL and testbench



---
 rtl/q_update_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_q_update_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_update_ctrl.sv
// q_update_ctrl: sequences one Q-learning update per agent step.
// Per step it reads Q[s,a], the reward/next-state ROMs and Qmax for the next
// and current states, hands the operands to the arithmetic pipeline, then
// writes the new Q value and, when it exceeds the stored maximum, Qmax[s].
// Episodes end when the terminal state is reached or the step limit expires.
module q_update_ctrl #(
  parameter int STATE_W   = 6,
  parameter int ACT_W     = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_STEPS = 64,
  parameter int STEP_W    = 7
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [STATE_W-1:0]         i_start_state,
  input  logic [STATE_W-1:0]         i_end_state,
  input  logic                       i_act_valid,
  input  logic [ACT_W-1:0]           i_act,
  output logic                       o_act_ready,
  output logic [STATE_W+ACT_W-1:0]   o_q_addr,
  output logic                       o_q_we,
  output logic [DATA_W-1:0]          o_q_wdata,
  input  logic [DATA_W-1:0]          i_q_rdata,
  output logic [STATE_W-1:0]         o_qmax_addr,
  output logic                       o_qmax_we,
  output logic [DATA_W-1:0]          o_qmax_wdata,
  input  logic [DATA_W-1:0]          i_qmax_rdata,
  output logic [STATE_W+ACT_W-1:0]   o_lut_addr,
  input  logic [DATA_W-1:0]          i_r,
  input  logic [STATE_W-1:0]         i_next_s,
  output logic                       o_calc_start,
  output logic [DATA_W-1:0]          o_q,
  output logic [DATA_W-1:0]          o_r,
  output logic [DATA_W-1:0]          o_qmax,
  input  logic                       i_calc_done,
  input  logic [DATA_W-1:0]          i_sum,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [STATE_W-1:0]         o_state,
  output logic [STEP_W-1:0]          o_steps
);

  localparam int AW = STATE_W + ACT_W;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_RD1, S_RD2, S_RD3, S_RD4, S_CALC, S_WB, S_NEXT, S_DONE
  } state_t;

  state_t              state_q;
  logic [STATE_W-1:0]  s_q;
  logic [STATE_W-1:0]  ns_q;
  logic [STEP_W-1:0]   steps_q;
  logic [DATA_W-1:0]   r_q;
  logic [DATA_W-1:0]   qval_q;
  logic [DATA_W-1:0]   qmax_next_q;
  logic [DATA_W-1:0]   qmax_cur_q;
  logic                calc_first_q;
  logic [AW-1:0]       q_addr_q;
  logic [AW-1:0]       lut_addr_q;
  logic [STATE_W-1:0]  qmax_addr_q;
  logic                q_we_q;
  logic                qmax_we_q;
  logic [DATA_W-1:0]   q_wdata_q;
  logic [DATA_W-1:0]   qmax_wdata_q;
  logic [DATA_W-1:0]   op_q_q;
  logic [DATA_W-1:0]   op_r_q;
  logic [DATA_W-1:0]   op_qmax_q;
  logic                busy_q;
  logic                done_q;
  logic [STEP_W-1:0]   steps_inc;

  assign steps_inc = steps_q + STEP_W'(1);

  // Step sequencer: state transitions, operand capture and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      s_q          <= '0;
      ns_q         <= '0;
      steps_q      <= '0;
      r_q          <= '0;
      qval_q       <= '0;
      qmax_next_q  <= '0;
      qmax_cur_q   <= '0;
      calc_first_q <= 1'b0;
      q_addr_q     <= '0;
      lut_addr_q   <= '0;
      qmax_addr_q  <= '0;
      q_we_q       <= 1'b0;
      qmax_we_q    <= 1'b0;
      q_wdata_q    <= '0;
      qmax_wdata_q <= '0;
      op_q_q       <= '0;
      op_r_q       <= '0;
      op_qmax_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            s_q     <= i_start_state;
            steps_q <= '0;
            busy_q  <= 1'b1;
            if (i_start_state == i_end_state) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ACT;
            end
          end
        end
        S_ACT: begin
          if (i_act_valid) begin
            q_addr_q   <= {s_q, i_act};
            lut_addr_q <= {s_q, i_act};
            state_q    <= S_RD1;
          end
        end
        S_RD1: begin
          // ROM outputs are combinational from the address registered at accept.
          r_q         <= i_r;
          ns_q        <= i_next_s;
          qmax_addr_q <= i_next_s;
          state_q     <= S_RD2;
        end
        S_RD2: begin
          qval_q      <= i_q_rdata;
          // The Qmax[ns] address has been sampled by the table at this edge, so
          // the Qmax[s] address can go out now and its data lands in RD4.
          qmax_addr_q <= s_q;
          state_q     <= S_RD3;
        end
        S_RD3: begin
          qmax_next_q <= i_qmax_rdata;
          state_q     <= S_RD4;
        end
        S_RD4: begin
          qmax_cur_q   <= i_qmax_rdata;
          op_q_q       <= qval_q;
          op_r_q       <= r_q;
          op_qmax_q    <= qmax_next_q;
          calc_first_q <= 1'b1;
          state_q      <= S_CALC;
        end
        S_CALC: begin
          calc_first_q <= 1'b0;
          if (i_calc_done) begin
            q_we_q       <= 1'b1;
            q_wdata_q    <= i_sum;
            qmax_we_q    <= (i_sum > qmax_cur_q);
            qmax_wdata_q <= i_sum;
            state_q      <= S_WB;
          end
        end
        S_WB: begin
          q_we_q    <= 1'b0;
          qmax_we_q <= 1'b0;
          state_q   <= S_NEXT;
        end
        S_NEXT: begin
          s_q     <= ns_q;
          steps_q <= steps_inc;
          if ((ns_q == i_end_state) || (steps_inc == LAST_STEP)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_ACT;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          q_we_q  <= 1'b0;
          qmax_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_act_ready  = (state_q == S_ACT);
  assign o_calc_start = (state_q == S_CALC) && calc_first_q;
  assign o_q_addr     = q_addr_q;
  assign o_lut_addr   = lut_addr_q;
  assign o_qmax_addr  = qmax_addr_q;
  assign o_q_we       = q_we_q;
  assign o_q_wdata    = q_wdata_q;
  assign o_qmax_we    = qmax_we_q;
  assign o_qmax_wdata = qmax_wdata_q;
  assign o_q          = op_q_q;
  assign o_r          = op_r_q;
  assign o_qmax       = op_qmax_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_state      = s_q;
  assign o_steps      = steps_q;

endmodule

// File: tb/tb_q_update_ctrl.sv
// Bench for q_update_ctrl: behavioural Q/Qmax tables and ROMs, directed
// episodes, and a write scoreboard fed when each action is accepted.
module tb_q_update_ctrl;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [5:0] i_start_state = '0;
  logic [5:0] i_end_state = '0;
  logic       i_act_valid = 1'b0;
  logic [1:0] i_act = '0;
  logic       o_act_ready;
  logic [7:0] o_q_addr;
  logic       o_q_we;
  logic [7:0] o_q_wdata;
  logic [7:0] q_rdata;
  logic [5:0] o_qmax_addr;
  logic       o_qmax_we;
  logic [7:0] o_qmax_wdata;
  logic [7:0] qmax_rdata;
  logic [7:0] o_lut_addr;
  logic [7:0] i_r;
  logic [5:0] i_next_s;
  logic       o_calc_start;
  logic [7:0] o_q, o_r, o_qmax;
  logic       i_calc_done = 1'b0;
  logic [7:0] i_sum = '0;
  logic       o_busy, o_done;
  logic [5:0] o_state;
  logic [6:0] o_steps;

  always #5 clk = ~clk;

  q_update_ctrl #(
    .STATE_W(6), .ACT_W(2), .DATA_W(8), .MAX_STEPS(4), .STEP_W(7)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_start_state(i_start_state), .i_end_state(i_end_state),
    .i_act_valid(i_act_valid), .i_act(i_act), .o_act_ready(o_act_ready),
    .o_q_addr(o_q_addr), .o_q_we(o_q_we), .o_q_wdata(o_q_wdata),
    .i_q_rdata(q_rdata), .o_qmax_addr(o_qmax_addr), .o_qmax_we(o_qmax_we),
    .o_qmax_wdata(o_qmax_wdata), .i_qmax_rdata(qmax_rdata),
    .o_lut_addr(o_lut_addr), .i_r(i_r), .i_next_s(i_next_s),
    .o_calc_start(o_calc_start), .o_q(o_q), .o_r(o_r), .o_qmax(o_qmax),
    .i_calc_done(i_calc_done), .i_sum(i_sum), .o_busy(o_busy),
    .o_done(o_done), .o_state(o_state), .o_steps(o_steps)
  );

  // Tables with one-cycle read latency, plus a preload port for the bench.
  logic [7:0] q_mem [256];
  logic [7:0] qmax_mem [64];
  logic [7:0] rom_r [256];
  logic [5:0] rom_ns [256];
  logic       ld_we = 1'b0;
  logic       ld_sel = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  always @(posedge clk) begin
    q_rdata    <= q_mem[o_q_addr];
    qmax_rdata <= qmax_mem[o_qmax_addr];
    if (o_q_we)    q_mem[o_q_addr]       <= o_q_wdata;
    if (o_qmax_we) qmax_mem[o_qmax_addr] <= o_qmax_wdata;
    if (ld_we) begin
      if (ld_sel) qmax_mem[ld_addr[5:0]] <= ld_data;
      else        q_mem[ld_addr]         <= ld_data;
    end
  end

  assign i_r      = rom_r[o_lut_addr];
  assign i_next_s = rom_ns[o_lut_addr];

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t exp_qw[$];
  wr_t exp_qmw[$];

  int checks = 0;
  int errors = 0;
  int nq_writes = 0;
  logic [5:0] m_s;
  int m_steps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard: every table write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (o_q_we === 1'b1) begin
      nq_writes++;
      if (exp_qw.size() == 0) check("q_we_unexpected", o_q_we, 0);
      else begin
        e = exp_qw.pop_front();
        check("q_waddr", o_q_addr, e.addr);
        check("q_wdata", o_q_wdata, e.data);
      end
    end
    if (o_qmax_we === 1'b1) begin
      if (exp_qmw.size() == 0) check("qmax_we_unexpected", o_qmax_we, 0);
      else begin
        e = exp_qmw.pop_front();
        check("qmax_waddr", o_qmax_addr, e.addr);
        check("qmax_wdata", o_qmax_wdata, e.data);
      end
    end
  end

  task automatic poke(input logic sel, input logic [7:0] addr, input logic [7:0] data);
    ld_we = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] s, input logic [5:0] e);
    i_start_state = s; i_end_state = e; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    m_s = s; m_steps = 0;
  endtask

  // One agent step from ACT; returns cycles spent until the FSM has left NEXT.
  task automatic do_step(input logic [1:0] act, input logic [7:0] sum,
                         input int act_delay, input int done_delay, output int cyc);
    logic [7:0] addr, eq, er, eqm, qcur;
    logic [5:0] ns;
    int n;
    addr = {m_s, act};
    eq = q_mem[addr]; er = rom_r[addr]; ns = rom_ns[addr];
    eqm = qmax_mem[ns]; qcur = qmax_mem[m_s];
    cyc = 0;
    for (int i = 0; i < act_delay; i++) begin
      check("act_hold", o_act_ready, 1);
      tick(); cyc++;
    end
    check("act_ready", o_act_ready, 1);
    i_act_valid = 1'b1; i_act = act;
    tick(); cyc++;
    i_act_valid = 1'b0; i_act = '0;
    exp_qw.push_back('{addr: addr, data: sum});
    if (sum > qcur) exp_qmw.push_back('{addr: {2'b00, m_s}, data: sum});
    check("q_addr", o_q_addr, addr);
    check("lut_addr", o_lut_addr, addr);
    check("ready_low", o_act_ready, 0);
    n = 0;
    while (o_calc_start !== 1'b1 && n < 20) begin
      tick(); n++;
    end
    cyc += n;
    check("calc_latency", n, 4);
    check("op_q", o_q, eq);
    check("op_r", o_r, er);
    check("op_qmax", o_qmax, eqm);
    for (int i = 0; i < done_delay; i++) begin
      tick(); cyc++;
      check("calc_start_once", o_calc_start, 0);
      check("op_q_hold", o_q, eq);
      check("op_qmax_hold", o_qmax, eqm);
      check("no_early_we", o_q_we, 0);
    end
    i_calc_done = 1'b1; i_sum = sum;
    tick(); cyc++;
    i_calc_done = 1'b0; i_sum = 8'hA5;
    check("wb_q_we", o_q_we, 1);
    check("wb_op_r_hold", o_r, er);
    check("wb_op_qmax_hold", o_qmax, eqm);
    tick(); cyc++;
    tick(); cyc++;
    m_s = ns; m_steps++;
  endtask

  task automatic load_single(input logic [7:0] qmax3);
    poke(1'b0, 8'd13, 8'd20);
    poke(1'b1, 8'd10, 8'd40);
    poke(1'b1, 8'd3, qmax3);
  endtask

  initial begin
    int cyc;
    int wr0;
    for (int i = 0; i < 256; i++) begin
      rom_r[i] = 8'(i + 1);
      rom_ns[i] = 6'(i >> 2);
    end
    rom_r[13] = 8'd5;  rom_ns[13] = 6'd10;
    rom_r[14] = 8'd2;  rom_ns[14] = 6'd3;

    // Power-on reset: every output low.
    tick(); tick();
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_q_addr", o_q_addr, 0);
    check("rst_q_we", o_q_we, 0);
    check("rst_state", o_state, 0);
    check("rst_steps", o_steps, 0);
    i_rst = 1'b0;
    tick();
    check("idle_ready", o_act_ready, 0);
    check("idle_busy", o_busy, 0);

    // Reset while waiting in CALC: abandoned with no write.
    load_single(8'd15);
    do_start(6'd3, 6'd10);
    i_act_valid = 1'b1; i_act = 2'd1;
    tick();
    i_act_valid = 1'b0;
    repeat (4) tick();
    check("midcalc_start", o_calc_start, 1);
    i_rst = 1'b1;
    #1;
    check("midcalc_busy", o_busy, 0);
    check("midcalc_q_addr", o_q_addr, 0);
    check("midcalc_qmax_addr", o_qmax_addr, 0);
    check("midcalc_lut_addr", o_lut_addr, 0);
    check("midcalc_op_q", o_q, 0);
    check("midcalc_state", o_state, 0);
    check("midcalc_calc_start", o_calc_start, 0);
    tick();
    check("midcalc_q_we", o_q_we, 0);
    i_rst = 1'b0;
    tick();
    check("midcalc_idle", o_busy, 0);
    check("midcalc_q13", q_mem[13], 20);

    // Single step with a new maximum.
    do_start(6'd3, 6'd10);
    check("ss_busy", o_busy, 1);
    check("ss_state", o_state, 3);
    do_step(2'd1, 8'd30, 0, 0, cyc);
    check("ss_cycles", cyc, 8);
    check("ss_done", o_done, 1);
    check("ss_final_state", o_state, 10);
    check("ss_steps", o_steps, 1);
    tick();
    check("ss_done_pulse", o_done, 0);
    check("ss_idle", o_busy, 0);
    check("ss_state_kept", o_state, 10);
    check("ss_q13", q_mem[13], 30);
    check("ss_qmax3", qmax_mem[3], 30);

    // Equal sum: no Qmax write.
    load_single(8'd30);
    do_start(6'd3, 6'd10);
    do_step(2'd1, 8'd30, 0, 0, cyc);
    check("nm_done", o_done, 1);
    tick();
    check("nm_q13", q_mem[13], 30);
    check("nm_qmax3", qmax_mem[3], 30);

    // Slow handshakes and a start pulse while busy.
    load_single(8'd15);
    do_start(6'd3, 6'd10);
    i_start_state = 6'd7; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("hs_state_kept", o_state, 3);
    do_step(2'd1, 8'd25, 4, 3, cyc);
    check("hs_done", o_done, 1);
    check("hs_steps", o_steps, 1);
    tick();

    // Step limit: self-loop on state 3 for MAX_STEPS=4.
    poke(1'b0, 8'd14, 8'd0);
    poke(1'b1, 8'd3, 8'd15);
    wr0 = nq_writes;
    do_start(6'd3, 6'd10);
    begin
      logic [7:0] sums [4];
      sums[0] = 8'd10; sums[1] = 8'd50; sums[2] = 8'd20; sums[3] = 8'd60;
      for (int k = 0; k < 4; k++) begin
        do_step(2'd2, sums[k], 0, 0, cyc);
        check("lim_cycles", cyc, 8);
        if (k < 3) check("lim_back_to_act", o_act_ready, 1);
      end
    end
    check("lim_done", o_done, 1);
    check("lim_steps", o_steps, 4);
    check("lim_state", o_state, 3);
    check("lim_writes", nq_writes - wr0, 4);
    tick();
    check("lim_qmax3", qmax_mem[3], 60);

    // Trivial episode: start equals end.
    wr0 = nq_writes;
    i_act_valid = 1'b1; i_act = 2'd0;
    do_start(6'd7, 6'd7);
    check("triv_done", o_done, 1);
    check("triv_steps", o_steps, 0);
    check("triv_state", o_state, 7);
    check("triv_ready", o_act_ready, 0);
    tick();
    check("triv_done_pulse", o_done, 0);
    check("triv_idle", o_busy, 0);
    i_act_valid = 1'b0;
    tick();
    check("triv_no_writes", nq_writes - wr0, 0);

    check("sb_q_empty", exp_qw.size(), 0);
    check("sb_qmax_empty", exp_qmw.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
